// File: rtl/hamming_pkg.sv
// Shared elaboration-time helpers for the Hamming stream encoder: code
// geometry (parity count, codeword width) and the data-bit -> codeword
// position map used to build parity masks and assemble the codeword.
package hamming_pkg;

  localparam int MAX_DATA_W = 57;
  localparam int MAX_POS    = 64;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < (data_w + r + 1)) r++;
    return r;
  endfunction

  // Codeword width including the overall-parity bit at position 0.
  function automatic int code_w(input int data_w);
    return data_w + calc_r(data_w) + 1;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bit idx sits at the idx-th non-power-of-two position (from 3 up).
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < MAX_POS; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Data bits covered by parity p_k: those whose position has bit k set.
  function automatic logic [MAX_DATA_W-1:0] par_mask(input int data_w, input int k);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < data_w; i++) begin
      if (((data_pos(i) >> k) & 1) != 0) m = m | (MAX_DATA_W'(1) << i);
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_pipe_stage.sv
// One valid/ready register slice. Accepts whenever empty or when the
// downstream consumer takes the held word on the same edge, so a chain
// of these streams one word per clock with no bubbles.
module hamming_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign in_ready_o  = !r_valid || out_ready_i;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;

  // Load a new word when the slot frees up; hold data stable while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      // NOTE: the data register is reset too, so the output bus reads zero after reset instead of stale X.
      r_data  <= '0;
    end else if (in_ready_o) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of block order.
      r_valid <= in_valid_i;
      if (in_valid_i) r_data <= in_data_i;
    end
  end

endmodule

// File: rtl/hamming_stream_encoder.sv
// Two-stage pipelined Hamming (SEC/SECDED) encoder with valid/ready on
// both sides, a one-shot bit-flip injector for exercising decoders, and a
// delivered-word counter. S1 holds payload + parity bits, S2 holds the
// assembled (and possibly corrupted) codeword.
module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [OUT_W-1:0]         package_o,
  input  logic                     inj_arm_i,
  input  logic [$clog2(OUT_W)-1:0] inj_pos_i,
  input  logic                     inj_dbl_i,
  output logic                     inj_busy_o,
  output logic [CNT_W-1:0]         word_cnt_o
);

  localparam int R      = calc_r(DATA_W);
  localparam int CODE_W = code_w(DATA_W);
  localparam int POS_W  = $clog2(OUT_W);
  localparam int S1_W   = DATA_W + R;

  if (DATA_W < 4 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("hamming_stream_encoder: DATA_W out of range 4..57");
  end
  if (OUT_W < CODE_W) begin : g_bad_out_w
    $error("hamming_stream_encoder: OUT_W smaller than the codeword width");
  end

  logic [R-1:0]       w_par;
  logic [S1_W-1:0]    w_s1_q;
  logic               w_s1_valid;
  logic               w_s2_in_ready;
  logic [R-1:0]       w_s1_par;
  logic [DATA_W-1:0]  w_s1_data;
  logic [OUT_W-1:0]   w_body;
  logic               w_overall;
  logic [OUT_W-1:0]   w_flip;
  logic [OUT_W-1:0]   w_s2_d;
  logic               w_move;

  logic               r_inj_busy;
  logic [POS_W-1:0]   r_inj_pos;
  logic               r_inj_dbl;
  logic [CNT_W-1:0]   r_word_cnt;

  // Parity p_k straight from the payload, using elaboration-time masks.
  for (genvar k = 0; k < R; k++) begin : g_par
    localparam logic [MAX_DATA_W-1:0] L_MASK = par_mask(DATA_W, k);
    assign w_par[k] = ^(data_i & L_MASK[DATA_W-1:0]);
  end

  hamming_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (s_valid_i),
    .in_ready_o  (s_ready_o),
    .in_data_i   ({w_par, data_i}),
    .out_valid_o (w_s1_valid),
    .out_ready_i (w_s2_in_ready),
    .out_data_o  (w_s1_q)
  );

  assign w_s1_par  = w_s1_q[S1_W-1:DATA_W];
  assign w_s1_data = w_s1_q[DATA_W-1:0];

  // Codeword body: parity at powers of two, payload in the remaining slots.
  for (genvar k = 0; k < R; k++) begin : g_put_par
    assign w_body[1 << k] = w_s1_par[k];
  end
  for (genvar i = 0; i < DATA_W; i++) begin : g_put_data
    localparam int L_POS = data_pos(i);
    assign w_body[L_POS] = w_s1_data[i];
  end
  assign w_body[0] = 1'b0;
  if (OUT_W > CODE_W) begin : g_pad
    assign w_body[OUT_W-1:CODE_W] = '0;
    assign w_flip[OUT_W-1:CODE_W] = '0;
  end

  assign w_overall = (SECDED != 0) ? ^w_body[CODE_W-1:1] : 1'b0;

  // Flip bit j when it is the armed position, or the one after it (mod CODE_W)
  // in double mode; positions >= CODE_W match nothing.
  for (genvar j = 0; j < CODE_W; j++) begin : g_flip
    localparam logic [POS_W-1:0] L_SELF = POS_W'(j);
    localparam logic [POS_W-1:0] L_PREV = POS_W'((j == 0) ? CODE_W - 1 : j - 1);
    assign w_flip[j] = r_inj_busy &
                       ((r_inj_pos == L_SELF) | (r_inj_dbl & (r_inj_pos == L_PREV)));
  end

  assign w_s2_d = {w_body[OUT_W-1:1], w_overall} ^ w_flip;
  assign w_move = w_s1_valid & w_s2_in_ready;

  hamming_pipe_stage #(.WIDTH(OUT_W)) u_s2 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (w_s1_valid),
    .in_ready_o  (w_s2_in_ready),
    .in_data_i   (w_s2_d),
    .out_valid_o (m_valid_o),
    .out_ready_i (m_ready_i),
    .out_data_o  (package_o)
  );

  // Injection arming: a new arm wins over consumption so it targets the next word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_inj_busy <= 1'b0;
      r_inj_pos  <= '0;
      r_inj_dbl  <= 1'b0;
    end else if (inj_arm_i) begin
      r_inj_busy <= 1'b1;
      r_inj_pos  <= inj_pos_i;
      r_inj_dbl  <= inj_dbl_i;
    end else if (w_move) begin
      r_inj_busy <= 1'b0;
    end
  end

  // Count words handed to the sink; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_word_cnt <= '0;
    end else if (m_valid_o && m_ready_i) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign inj_busy_o = r_inj_busy;
  assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Bench for hamming_stream_encoder: default SECDED instance, a SEC-only
// instance and a 32-bit-wide instance, all compared against a positional
// Hamming model computed inside the bench.
module tb_hamming_stream_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance (DATA_W=8, OUT_W=16, SECDED=1, CNT_W=16)
  logic        s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1;
  logic [7:0]  data = '0;
  logic [15:0] pkg, cnt;
  logic        inj_arm = 1'b0, inj_dbl = 1'b0, inj_busy;
  logic [3:0]  inj_pos = '0;

  // SEC-only instance
  logic        z_s_valid = 1'b0, z_s_ready, z_m_valid, z_busy;
  logic [7:0]  z_data = '0;
  logic [15:0] z_pkg, z_cnt;

  // Wide instance (DATA_W=32, OUT_W=40, CNT_W=4)
  logic        wd_s_valid = 1'b0, wd_s_ready, wd_m_valid, wd_m_ready = 1'b1, wd_busy;
  logic [31:0] wd_data = '0;
  logic [39:0] wd_pkg;
  logic [3:0]  wd_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hamming_stream_encoder u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .data_i(data), .m_valid_o(m_valid), .m_ready_i(m_ready), .package_o(pkg),
    .inj_arm_i(inj_arm), .inj_pos_i(inj_pos), .inj_dbl_i(inj_dbl),
    .inj_busy_o(inj_busy), .word_cnt_o(cnt));

  hamming_stream_encoder #(.SECDED(0)) u_dut_sec (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(z_s_valid), .s_ready_o(z_s_ready),
    .data_i(z_data), .m_valid_o(z_m_valid), .m_ready_i(1'b1), .package_o(z_pkg),
    .inj_arm_i(1'b0), .inj_pos_i(4'd0), .inj_dbl_i(1'b0),
    .inj_busy_o(z_busy), .word_cnt_o(z_cnt));

  hamming_stream_encoder #(.DATA_W(32), .OUT_W(40), .CNT_W(4)) u_dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(wd_s_valid), .s_ready_o(wd_s_ready),
    .data_i(wd_data), .m_valid_o(wd_m_valid), .m_ready_i(wd_m_ready), .package_o(wd_pkg),
    .inj_arm_i(1'b0), .inj_pos_i(6'd0), .inj_dbl_i(1'b0),
    .inj_busy_o(wd_busy), .word_cnt_o(wd_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: place data at non-power-of-two positions, then each parity
  // at 2^k is the XOR of every position having bit k set.
  function automatic logic [63:0] model(input logic [63:0] d, input int dw, input bit secded);
    logic [63:0] c;
    int r, n, di;
    bit p;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    n = dw + r + 1;
    c = '0;
    di = 0;
    for (int pos = 1; pos < n; pos++)
      if ((pos & (pos - 1)) != 0) begin c[pos] = d[di]; di++; end
    for (int k = 0; k < r; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < n; pos++) if ((pos & (1 << k)) != 0) p ^= c[pos];
      c[1 << k] = p;
    end
    if (secded) c[0] = ^c;
    return c;
  endfunction

  task automatic send_d(input logic [7:0] d, output logic [15:0] p, output int lat);
    s_valid = 1'b1; data = d; lat = 0;
    @(posedge clk); #1;
    s_valid = 1'b0; lat = 1;
    while (!m_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    p = pkg;
  endtask

  task automatic send_w(input logic [31:0] d, output logic [39:0] p, output int lat);
    wd_s_valid = 1'b1; wd_data = d; lat = 0;
    @(posedge clk); #1;
    wd_s_valid = 1'b0; lat = 1;
    while (!wd_m_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    p = wd_pkg;
  endtask

  task automatic arm(input logic [3:0] pos, input logic dbl);
    inj_arm = 1'b1; inj_pos = pos; inj_dbl = dbl;
    @(posedge clk); #1;
    inj_arm = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    logic [39:0] pw;
    logic [31:0] dw;
    logic [15:0] base, held_pkt;
    logic [15:0] exp_q[$];
    int lat, sent, recv, cyc;
    bit held;

    // ---- reset state
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_package", pkg, 0);
    check("rst_busy", inj_busy, 0);
    check("rst_cnt", cnt, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed encodings and latency
    send_d(8'hA5, p, lat); check("lat_A5", lat, 2); check("enc_A5", p, 16'h144E);
    send_d(8'h00, p, lat); check("enc_00", p, 16'h0000);
    send_d(8'hFF, p, lat); check("enc_FF", p, 16'h1EEE);
    check("model_A5", model(64'hA5, 8, 1), 64'h144E);

    // ---- SEC-only vs SECDED
    z_s_valid = 1'b1; z_data = 8'h01;
    @(posedge clk); #1; z_s_valid = 1'b0;
    @(posedge clk); #1;
    check("sec_valid", z_m_valid, 1);
    check("sec_01", z_pkg, 16'h000E);
    send_d(8'h01, p, lat); check("secded_01", p, 16'h000F);
    for (int i = 0; i < 4; i++) begin
      z_data = 8'($urandom); z_s_valid = 1'b1;
      @(posedge clk); #1; z_s_valid = 1'b0;
      @(posedge clk); #1;
      check("sec_rand", z_pkg, model(64'(z_data), 8, 0));
    end

    // ---- injection
    @(posedge clk); #1;
    arm(4'd3, 1'b0); check("inj_busy_set", inj_busy, 1);
    send_d(8'hA5, p, lat); check("inj_pos3", p, 16'h1446); check("inj_busy_clr", inj_busy, 0);
    send_d(8'hA5, p, lat); check("inj_oneshot", p, 16'h144E);
    arm(4'd3, 1'b1); send_d(8'hA5, p, lat); check("inj_dbl", p, 16'h1456);
    arm(4'd15, 1'b0); send_d(8'hA5, p, lat); check("inj_pos15", p, 16'h144E);
    check("inj_pos15_consumed", inj_busy, 0);
    arm(4'd0, 1'b0); send_d(8'hA5, p, lat); check("inj_pos0", p, 16'h144F);
    arm(4'd12, 1'b1); send_d(8'hA5, p, lat); check("inj_dbl_wrap", p, 16'h044F);
    arm(4'd3, 1'b0); arm(4'd5, 1'b0); send_d(8'hA5, p, lat); check("inj_rearm", p, 16'h146E);
    // Arm on the same edge as a S1->S2 move: that word is clean, next one hit.
    s_valid = 1'b1; data = 8'h00;
    @(posedge clk); #1;
    s_valid = 1'b0; inj_arm = 1'b1; inj_pos = 4'd3; inj_dbl = 1'b0;
    @(posedge clk); #1;
    inj_arm = 1'b0;
    check("inj_same_edge_word", pkg, 16'h0000);
    check("inj_same_edge_busy", inj_busy, 1);
    send_d(8'h00, p, lat); check("inj_same_edge_next", p, 16'h0008);

    // ---- asynchronous reset mid-stream
    @(posedge clk); #1;
    m_ready = 1'b0; s_valid = 1'b1; data = 8'h11;
    @(posedge clk); #1;
    data = 8'h22; inj_arm = 1'b1; inj_pos = 4'd3;
    @(posedge clk); #1;
    s_valid = 1'b0; inj_arm = 1'b0;
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_busy", inj_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_busy", inj_busy, 0);
    check("arst_cnt", cnt, 0);
    check("arst_package", pkg, 0);
    @(posedge clk); #3; rst_n = 1'b1; m_ready = 1'b1;
    check("post_rst_ready", s_ready, 1);
    @(posedge clk); #1;
    check("post_rst_no_word", m_valid, 0);
    send_d(8'hFF, p, lat); check("post_rst_enc", p, 16'h1EEE);
    @(posedge clk); #1;
    check("post_rst_cnt", cnt, 1);

    // ---- back-to-back stream 0..255 with random backpressure
    base = cnt; sent = 0; recv = 0; cyc = 0; held = 1'b0; held_pkt = '0;
    for (int i = 0; i < 256; i++) exp_q.push_back(16'(model(64'(i), 8, 1)));
    while (recv < 256 && cyc < 4000) begin
      s_valid = (sent < 256); data = 8'(sent); m_ready = 1'($urandom_range(0, 1));
      #3;
      if (held) begin
        check("stall_valid", m_valid, 1);
        check("stall_stable", pkg, held_pkt);
      end
      if (m_valid && m_ready) begin
        check("stream_word", pkg, exp_q[recv]);
        recv++; held = 1'b0;
      end else if (m_valid) begin
        held = 1'b1; held_pkt = pkg;
      end else held = 1'b0;
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    check("stream_received", recv, 256);
    check("stream_sent", sent, 256);
    check("stream_cnt", cnt, base + 16'd256);
    repeat (3) @(posedge clk);
    #1;
    check("stream_no_dup", m_valid, 0);

    // ---- wide configuration, counter wrap at CNT_W=4
    for (int i = 0; i < 16; i++) begin
      dw = $urandom;
      send_w(dw, pw, lat);
      check("wide_lat", lat, 2);
      check("wide_word", pw, model(64'(dw), 32, 1));
      check("wide_bit39", pw[39], 0);
      @(posedge clk); #1;
      if (i == 14) check("wide_cnt15", wd_cnt, 4'd15);
      if (i == 15) check("wide_cnt_wrap", wd_cnt, 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
